// File: rtl/vc_arb_pkg.sv
// Shared flit-type definitions for the VC injection arbiter.
// Flit type lives in the top IDENTIFIER_BITS of each flit.
package vc_arb_pkg;

   localparam int IDENTIFIER_BITS_DEF = 2;

   typedef enum logic [1:0] {
      HEAD = 2'b01,
      BODY = 2'b10,
      TAIL = 2'b11
   } flit_type_e;

   // 2'b00 is illegal on the wire and folds into BODY
   function automatic flit_type_e flit_type(
      input logic [IDENTIFIER_BITS_DEF-1:0] id
   );
      case (id)
         2'b01:   return HEAD;
         2'b11:   return TAIL;
         default: return BODY;
      endcase
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first request at or after ptr wins.
// N must be a power of two so the index wraps by truncation.
module rr_priority_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant_onehot,
   output logic [$clog2(N)-1:0] grant_idx,
   output logic                 any
);

   localparam int W = $clog2(N);

   logic [W-1:0] idx;

   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      any          = 1'b0;
      idx          = '0;
      for (int k = 0; k < N; k++) begin
         idx = ptr + W'(k);
         if (!any && req[idx]) begin
            any               = 1'b1;
            grant_idx         = idx;
            grant_onehot[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vc_injection_arbiter.sv
// Packet-granular round-robin arbiter onto one registered injection link.
// Define VC_ARB_STATS_EN to add packets_granted/stall_cycles counters.
module vc_injection_arbiter
   import vc_arb_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int VC              = 4,
   parameter int IDENTIFIER_BITS = IDENTIFIER_BITS_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [VC*DATA_WIDTH-1:0] data_in,
   input  logic [VC-1:0]            valid_in,
   output logic [VC-1:0]            ready_in,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     valid_out,
   input  logic                     ready_out,
   output logic [$clog2(VC)-1:0]    current_vc,
   output logic                     locked,
   output logic                     protocol_error
`ifdef VC_ARB_STATS_EN
   ,
   output logic [VC*32-1:0]         packets_granted,
   output logic [31:0]              stall_cycles
`endif
);

   localparam int VW = $clog2(VC);

   typedef enum logic {
      IDLE,
      LOCKED
   } state_e;

   state_e                state, state_n;
   logic [VW-1:0]         rr_ptr, sel_vc;
   logic [DATA_WIDTH-1:0] flit [VC];
   flit_type_e            ftype [VC];
   logic [VC-1:0]         head_req, grant_onehot;
   logic [VW-1:0]         grant_idx;
   logic                  grant_any;
   logic                  can_load, take, tail_acc, err_set;

   for (genvar i = 0; i < VC; i++) begin : g_vc
      assign flit[i]     = data_in[i*DATA_WIDTH +: DATA_WIDTH];
      assign ftype[i]    = flit_type(flit[i][DATA_WIDTH-1 -: IDENTIFIER_BITS]);
      assign head_req[i] = valid_in[i] && (ftype[i] == HEAD);
   end

   rr_priority_picker #(
      .N(VC)
   ) u_pick (
      .req          (head_req),
      .ptr          (rr_ptr),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .any          (grant_any)
   );

   assign can_load = !valid_out || ready_out;
   assign locked   = (state == LOCKED);

   always_comb begin
      state_n  = state;
      ready_in = '0;
      sel_vc   = current_vc;
      take     = 1'b0;
      tail_acc = 1'b0;
      err_set  = 1'b0;
      unique case (state)
         IDLE: begin
            err_set = |(valid_in & ~head_req);
            if (grant_any && can_load) begin
               ready_in = grant_onehot;
               sel_vc   = grant_idx;
               take     = 1'b1;
               state_n  = LOCKED;
            end
         end
         LOCKED: begin
            // heads on the owning VC pass through as plain data
            if (valid_in[current_vc] && can_load) begin
               ready_in[current_vc] = 1'b1;
               take                 = 1'b1;
               if (ftype[current_vc] == TAIL) begin
                  tail_acc = 1'b1;
                  state_n  = IDLE;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         current_vc     <= '0;
         valid_out      <= 1'b0;
         data_out       <= '0;
         protocol_error <= 1'b0;
      end else begin
         state      <= state_n;
         current_vc <= sel_vc;
         if (take) begin
            data_out  <= flit[sel_vc];
            valid_out <= 1'b1;
         end else if (ready_out) begin
            valid_out <= 1'b0;
         end
         if (tail_acc)
            rr_ptr <= current_vc + VW'(1);
         if (err_set)
            protocol_error <= 1'b1;
      end
   end

`ifdef VC_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         packets_granted <= '0;
         stall_cycles    <= '0;
      end else begin
         if (tail_acc)
            packets_granted[current_vc*32 +: 32] <=
               packets_granted[current_vc*32 +: 32] + 32'd1;
         if (valid_out && !ready_out)
            stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vc_injection_arbiter.sv
// Bench for vc_injection_arbiter: directed scenarios plus random packets
// checked against a packet-level round-robin order model.
module tb_vc_injection_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] data_in;
   logic [3:0]   valid_in;
   logic [3:0]   ready_in;
   logic [31:0]  data_out;
   logic         valid_out;
   logic         ready_out;
   logic [1:0]   current_vc;
   logic         locked;
   logic         protocol_error;
`ifdef VC_ARB_STATS_EN
   logic [127:0] packets_granted;
   logic [31:0]  stall_cycles;
`endif

   logic [31:0] din [4];
   int vectors = 0;
   int miscompares = 0;

   assign data_in = {din[3], din[2], din[1], din[0]};

   always #5 clk = ~clk;

   vc_injection_arbiter #(
      .DATA_WIDTH(32), .VC(4), .IDENTIFIER_BITS(2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (data_in),
      .valid_in       (valid_in),
      .ready_in       (ready_in),
      .data_out       (data_out),
      .valid_out      (valid_out),
      .ready_out      (ready_out),
      .current_vc     (current_vc),
      .locked         (locked),
      .protocol_error (protocol_error)
`ifdef VC_ARB_STATS_EN
      ,
      .packets_granted(packets_granted),
      .stall_cycles   (stall_cycles)
`endif
   );

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      valid_in = '0;
      ready_out = 1'b0;
      for (int i = 0; i < 4; i++) din[i] = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL rst_valid_out got %b exp 0", valid_out); end
      vectors++; if (data_out !== 32'h0) begin miscompares++; $display("FAIL rst_data_out got %h exp 0", data_out); end
      vectors++; if (ready_in !== 4'h0) begin miscompares++; $display("FAIL rst_ready_in got %b exp 0000", ready_in); end
      vectors++; if (current_vc !== 2'd0) begin miscompares++; $display("FAIL rst_current_vc got %0d exp 0", current_vc); end
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rst_locked got %b exp 0", locked); end
      vectors++; if (protocol_error !== 1'b0) begin miscompares++; $display("FAIL rst_perr got %b exp 0", protocol_error); end
      @(negedge clk);
   endtask

   task automatic test_single_packet();
      logic [31:0] pk [3];
      pk[0] = 32'h4000_0005; pk[1] = 32'h8000_0001; pk[2] = 32'hC000_0002;
      do_reset();
      ready_out = 1'b1;
      for (int f = 0; f < 3; f++) begin
         din[2] = pk[f]; valid_in = 4'b0100;
         #1;
         vectors++; if (ready_in !== 4'b0100) begin miscompares++; $display("FAIL sp_ready flit%0d got %b exp 0100", f, ready_in); end
         cycle();
         vectors++; if (valid_out !== 1'b1 || data_out !== pk[f]) begin miscompares++; $display("FAIL sp_data flit%0d got %b/%h exp 1/%h", f, valid_out, data_out, pk[f]); end
         vectors++; if (locked !== (f != 2)) begin miscompares++; $display("FAIL sp_locked flit%0d got %b exp %b", f, locked, f != 2); end
      end
      vectors++; if (current_vc !== 2'd2) begin miscompares++; $display("FAIL sp_current_vc got %0d exp 2", current_vc); end
      // rr_ptr must now be 3: VC3 beats VC0
      din[0] = 32'h4000_0100; din[3] = 32'h4000_0300; valid_in = 4'b1001;
      #1;
      vectors++; if (ready_in !== 4'b1000) begin miscompares++; $display("FAIL sp_rr_ptr got %b exp 1000", ready_in); end
      cycle();
      din[3] = 32'hC000_0301; valid_in = 4'b1000;
      cycle();
      valid_in = '0;
      cycle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] srcq [4][$];
      logic [31:0] exp_s [$];
      logic [3:0]  acc;
      logic [31:0] w;
      do_reset();
      for (int v = 0; v < 4; v++) begin
         for (int f = 0; f < 2; f++) begin
            w = (f == 0) ? 32'h4000_0000 : 32'hC000_0000;
            w[7:0] = 8'((v << 4) | f);
            srcq[v].push_back(w);
            exp_s.push_back(w);
         end
      end
      ready_out = 1'b1;
      for (int k = 0; k < 8; k++) begin
         for (int v = 0; v < 4; v++) begin
            valid_in[v] = (srcq[v].size() > 0);
            din[v] = valid_in[v] ? srcq[v][0] : 32'h0;
         end
         #1;
         acc = ready_in & valid_in;
         @(posedge clk);
         for (int v = 0; v < 4; v++) if (acc[v]) void'(srcq[v].pop_front());
         #1;
         vectors++; if (valid_out !== 1'b1 || data_out !== exp_s[k]) begin miscompares++; $display("FAIL b2b cycle%0d got %b/%h exp 1/%h", k, valid_out, data_out, exp_s[k]); end
         @(negedge clk);
      end
      valid_in = '0;
      cycle();
   endtask

   task automatic test_lock_hold();
      do_reset();
      ready_out = 1'b1;
      din[1] = 32'h4000_0011; valid_in = 4'b0010;
      cycle();
      din[0] = 32'h4000_0100; din[1] = 32'h8000_0012; valid_in = 4'b0011;
      #1;
      vectors++; if (ready_in !== 4'b0010) begin miscompares++; $display("FAIL lock_body got %b exp 0010", ready_in); end
      cycle();
      din[1] = 32'hC000_0013;
      #1;
      vectors++; if (ready_in !== 4'b0010) begin miscompares++; $display("FAIL lock_tail got %b exp 0010", ready_in); end
      cycle();
      valid_in = 4'b0001;
      #1;
      vectors++; if (ready_in !== 4'b0001) begin miscompares++; $display("FAIL lock_next got %b exp 0001", ready_in); end
      cycle();
      vectors++; if (data_out !== 32'h4000_0100 || current_vc !== 2'd0) begin miscompares++; $display("FAIL lock_grant got %h/%0d exp 40000100/0", data_out, current_vc); end
      din[0] = 32'hC000_0101;
      cycle();
      valid_in = '0;
      cycle();
   endtask

   task automatic test_stall();
      do_reset();
      ready_out = 1'b1;
      din[0] = 32'h4000_0AA0; valid_in = 4'b0001;
      cycle();
      din[0] = 32'h8000_0AAA;
      cycle();
      ready_out = 1'b0;
      din[0] = 32'hC000_0AAB; din[2] = 32'h4000_0200; valid_in = 4'b0101;
      for (int k = 0; k < 5; k++) begin
         #1;
         vectors++; if (ready_in !== 4'b0000) begin miscompares++; $display("FAIL stall_ready c%0d got %b exp 0000", k, ready_in); end
         vectors++; if (valid_out !== 1'b1 || data_out !== 32'h8000_0AAA) begin miscompares++; $display("FAIL stall_hold c%0d got %b/%h exp 1/80000aaa", k, valid_out, data_out); end
         vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL stall_lock c%0d got %b exp 1", k, locked); end
         cycle();
      end
      ready_out = 1'b1;
      #1;
      vectors++; if (ready_in !== 4'b0001) begin miscompares++; $display("FAIL stall_resume got %b exp 0001", ready_in); end
      cycle();
      vectors++; if (data_out !== 32'hC000_0AAB) begin miscompares++; $display("FAIL stall_tail got %h exp c0000aab", data_out); end
      valid_in = 4'b0100;
      cycle();
      vectors++; if (data_out !== 32'h4000_0200 || current_vc !== 2'd2) begin miscompares++; $display("FAIL stall_next got %h/%0d exp 40000200/2", data_out, current_vc); end
      din[2] = 32'hC000_0201;
      cycle();
      valid_in = '0;
      cycle();
   endtask

   task automatic test_protocol_error();
      do_reset();
      ready_out = 1'b1;
      din[3] = 32'h8000_0000; valid_in = 4'b1000;
      #1;
      vectors++; if (ready_in !== 4'b0000) begin miscompares++; $display("FAIL perr_ready got %b exp 0000", ready_in); end
      cycle();
      vectors++; if (protocol_error !== 1'b1 || valid_out !== 1'b0) begin miscompares++; $display("FAIL perr_set got %b/%b exp 1/0", protocol_error, valid_out); end
      din[0] = 32'h4000_0001; valid_in = 4'b0001;
      cycle();
      din[0] = 32'hC000_0002;
      cycle();
      valid_in = '0;
      cycle();
      vectors++; if (protocol_error !== 1'b1) begin miscompares++; $display("FAIL perr_sticky got %b exp 1", protocol_error); end
   endtask

   task automatic test_async_reset();
      do_reset();
      ready_out = 1'b1;
      din[0] = 32'h4000_0001; valid_in = 4'b0001;
      cycle();
      din[0] = 32'hC000_0002;
      cycle();
      din[1] = 32'h4000_0003; valid_in = 4'b0010;
      cycle();
      ready_out = 1'b0; valid_in = '0;
      cycle();
      cycle();
      vectors++; if (locked !== 1'b1 || valid_out !== 1'b1) begin miscompares++; $display("FAIL ar_pre got %b/%b exp 1/1", locked, valid_out); end
`ifdef VC_ARB_STATS_EN
      vectors++; if (packets_granted !== 128'd1 || stall_cycles !== 32'd2) begin miscompares++; $display("FAIL ar_stats_pre got %h/%0d exp 1/2", packets_granted, stall_cycles); end
`endif
      #2 rst = 1'b0;
      #1;
      vectors++; if (valid_out !== 1'b0 || locked !== 1'b0 || data_out !== 32'h0) begin miscompares++; $display("FAIL ar_async got %b/%b/%h exp 0/0/0", valid_out, locked, data_out); end
`ifdef VC_ARB_STATS_EN
      vectors++; if (packets_granted !== 128'd0 || stall_cycles !== 32'd0) begin miscompares++; $display("FAIL ar_stats got %h/%0d exp 0/0", packets_granted, stall_cycles); end
`endif
      @(negedge clk);
      rst = 1'b1;
      cycle();
   endtask

   task automatic test_random(input int iter);
      logic [31:0] srcq [4][$];
      logic [31:0] cp [4][$];
      int          lens [4][$];
      logic [31:0] expq [$];
      logic [31:0] w, e;
      logic [3:0]  acc;
      int          len, ptr, budget;
      bit          found, pend;
      do_reset();
      for (int v = 0; v < 4; v++) begin
         for (int p = $urandom_range(1, 3); p > 0; p--) begin
            len = $urandom_range(2, 5);
            lens[v].push_back(len);
            for (int f = 0; f < len; f++) begin
               w = $urandom;
               if (f == 0) w[31:30] = 2'b01;
               else if (f == len - 1) w[31:30] = 2'b11;
               else w[31:30] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
               srcq[v].push_back(w);
               cp[v].push_back(w);
            end
         end
      end
      // whole packets leave in rotating VC order, skipping exhausted VCs
      ptr = 0;
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         for (int off = 0; off < 4; off++) begin
            int v;
            v = (ptr + off) % 4;
            if (!found && lens[v].size() > 0) begin
               found = 1'b1;
               len = lens[v].pop_front();
               repeat (len) expq.push_back(cp[v].pop_front());
               ptr = (v + 1) % 4;
            end
         end
      end
      budget = 0;
      pend = 1'b1;
      while ((pend || expq.size() > 0) && budget < 3000) begin
         for (int v = 0; v < 4; v++) begin
            valid_in[v] = (srcq[v].size() > 0);
            din[v] = valid_in[v] ? srcq[v][0] : 32'h0;
         end
         ready_out = ($urandom_range(0, 3) != 0);
         #1;
         vectors++; if (!$onehot0(ready_in) || (ready_in & ~valid_in) != 4'h0) begin miscompares++; $display("FAIL rnd%0d_ready got %b valid %b", iter, ready_in, valid_in); end
         if (valid_out && ready_out) begin
            vectors++;
            if (expq.size() == 0) begin miscompares++; $display("FAIL rnd%0d_extra got %h exp none", iter, data_out); end
            else begin
               e = expq.pop_front();
               if (data_out !== e) begin miscompares++; $display("FAIL rnd%0d_data got %h exp %h", iter, data_out, e); end
            end
         end
         acc = ready_in & valid_in;
         @(posedge clk);
         pend = 1'b0;
         for (int v = 0; v < 4; v++) begin
            if (acc[v]) void'(srcq[v].pop_front());
            if (srcq[v].size() > 0) pend = 1'b1;
         end
         @(negedge clk);
         budget++;
      end
      valid_in = '0;
      vectors++; if (budget >= 3000) begin miscompares++; $display("FAIL rnd%0d_timeout got %0d left exp 0", iter, expq.size()); end
      vectors++; if (locked !== 1'b0 || protocol_error !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_end got %b/%b exp 0/0", iter, locked, protocol_error); end
   endtask

   initial begin
      rst = 1'b0;
      valid_in = '0;
      ready_out = 1'b0;
      for (int i = 0; i < 4; i++) din[i] = '0;
      test_reset();
      test_single_packet();
      test_back_to_back();
      test_lock_hold();
      test_stall();
      test_protocol_error();
      test_async_reset();
      for (int it = 0; it < 6; it++) test_random(it);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vc_injection_arbiter.md
# vc_injection_arbiter

Wormhole arbiter sharing one node injection link among `VC` virtual-channel flit sources. It sits between per-VC traffic sources (node verifiers or NI queues) and the router local input port. Grants are round-robin at packet granularity: once a head flit wins, that VC owns the link until its tail flit leaves. Output is a one-deep registered stage with valid/ready flow control.

## Interface
- `DATA_WIDTH`, 32: flit width.
- `VC`, 4: number of requesting virtual channels, ≥2, power of two.
- `IDENTIFIER_BITS`, 2: flit-type field at `[DATA_WIDTH-1 -: IDENTIFIER_BITS]`.

- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `data_in`  in  VC*DATA_WIDTH  per-VC flits, VC i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `valid_in`  in  VC  per-VC flit valid.
- `ready_in`  out  VC  per-VC accept; at most one bit high per cycle.
- `data_out`  out  DATA_WIDTH  registered flit to router.
- `valid_out`  out  1  registered valid.
- `ready_out`  in  1  router accept.
- `current_vc`  out  $clog2(VC)  VC owning the link, or last owner when idle.
- `locked`  out  1  packet in flight (head sent, tail not yet accepted into output register).
- `protocol_error`  out  1  sticky; set on a non-head flit from an unlocked VC.

## Operation
- Flit types: head 2'b01, body 2'b10, tail 2'b11. 2'b00 is illegal and treated as body.
- FSM states: IDLE, LOCKED.
- IDLE: candidates are VCs with `valid_in` high and a head flit. Search starts at `rr_ptr`; first candidate wins. Winner's `ready_in` is raised when the output register can load. The flit is loaded, `current_vc` becomes the winner, and the FSM goes to LOCKED.
- LOCKED: only `current_vc` may transfer. Other VCs' `ready_in` stay 0 even if valid.
- Tail flit accepted while LOCKED: FSM returns to IDLE and `rr_ptr` becomes `current_vc+1` (mod VC, wraps VC-1→0).
- A head flit on the locked VC while LOCKED is forwarded as ordinary data. No re-arbitration.
- A non-head flit from an unlocked VC in IDLE is not accepted and sets `protocol_error`, which only reset clears.
- Output register can load when `!valid_out || ready_out`, so full throughput is one flit per cycle under back-to-back ready.
- `ready_in` is combinational from `valid_in`, state and `ready_out`. `data_out` and `valid_out` are flop outputs.

## Timing
- Reset values: `valid_out`=0, `data_out`=0, `ready_in`=0, `current_vc`=0, `locked`=0, `protocol_error`=0, `rr_ptr`=0, FSM=IDLE.
- Latency: a flit accepted at edge N (`valid_in[i] & ready_in[i]`) appears on `data_out` with `valid_out`=1 from edge N onward.
- `data_out` holds stable while `valid_out & !ready_out`.
- Tail accept at edge N: a new head from another VC may be accepted at edge N+1. There are no bubbles between packets when `ready_out`=1.
- Simultaneous heads on all VCs after reset: the grant order is 0, 1, 2, 3, 0, …
- `ready_out` low for K cycles while locked: no flits are lost and the lock persists.
- Reset asserted mid-packet: the in-flight flit is dropped, `valid_out`=0 and the FSM goes to IDLE. Sources must restart their packets.

## Configuration
- `VC_ARB_STATS_EN` defined: adds output ports `packets_granted` [VC*32], a per-VC count of tails accepted, and `stall_cycles` [32], a count of cycles with `valid_out & !ready_out`.
  - All counters reset to 0 and wrap at 2^32.
- Not defined: those ports and their counters do not exist. Arbitration behaviour is identical in both builds.

## Structure
- Package `vc_arb_pkg` holds:
  - enum `flit_type_e` (HEAD, BODY, TAIL)
  - the `IDENTIFIER_BITS` default
  - function `flit_type(flit)`
- Sub-module `rr_priority_picker` (parameter `N`; ports `req[N]`, `ptr`, `grant_onehot`, `grant_idx`, `any`) is purely combinational and rotates priority from `ptr`.
- FSM, `rr_ptr`, output register, error flag and optional stats stay in the top module.

## Test plan
- Reset, then VC2 sends 3-flit packet 0x4000_0005, 0x8000_0001, 0xC000_0002 with `ready_out`=1 → `data_out` matches on 3 consecutive cycles; `locked` falls after the tail; `current_vc`=2; `rr_ptr`=3.
- All 4 VCs hold 2-flit packets from cycle 0 → grant order VC0, VC1, VC2, VC3, with 8 flits on 8 consecutive cycles and no interleaving.
- VC1 locked mid-packet while VC0 presents a head → `ready_in[0]`=0 until VC1's tail is accepted, then VC0 is granted the next cycle.
- `ready_out` deasserted for 5 cycles during a body flit → `data_out` stable, `valid_out`=1, no `ready_in` high; the stream resumes in order.
- VC3 presents body flit 0x8000_0000 in IDLE → not accepted, `protocol_error`=1, and it stays 1 after later valid packets.
- `rst` asserted low asynchronously mid-packet, between edges → `valid_out`=0 and `locked`=0 immediately. With `VC_ARB_STATS_EN`, counters read 0.
